// File: rtl/delay_scheduler_if.sv
// Requester, control and delayed-output signals of the shared delay pipeline.
// The master side drives requests and hold; the slave side is the scheduler.
interface delay_scheduler_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ),
    parameter int CNTW  = 16
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  hold;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [IDW-1:0]        out_id;
    logic                  busy;
    logic [CNTW-1:0]       accept_cnt;

    modport master (
        output req_valid, req_data, hold,
        input  req_ready, out_valid, out_data, out_id, busy, accept_cnt
    );

    modport slave (
        input  req_valid, req_data, hold,
        output req_ready, out_valid, out_data, out_id, busy, accept_cnt
    );
endinterface

// File: rtl/delay_scheduler.sv
// Round-robin arbiter feeding one shared fixed-latency delay pipeline; each word
// leaves DEPTH unheld cycles after acceptance, tagged with its requester index.
module delay_scheduler #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ),
    parameter int DEPTH = 2,
    parameter int CNTW  = 16
) (
    input  logic clk,
    input  logic rst_n,
    delay_scheduler_if.slave bus
);
    logic [IDW-1:0]              ptr;
    logic [IDW-1:0]              win;
    logic [IDW:0]                cand;
    logic                        found;
    logic                        transfer;
    logic [WIDTH-1:0]            win_data;
    logic [NREQ-1:0]             ready;
    logic [DEPTH-1:0]            st_valid;
    logic [DEPTH-1:0][IDW-1:0]   st_id;
    logic [DEPTH-1:0][WIDTH-1:0] st_data;
    logic [CNTW-1:0]             cnt;

    // Search ptr, ptr+1, ... modulo NREQ; cand is one bit wider so the sum
    // cannot overflow before the modulo fold.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!found && bus.req_valid[cand[IDW-1:0]]) begin
                found = 1'b1;
                win   = cand[IDW-1:0];
            end
        end
    end

    assign transfer = found & ~bus.hold & rst_n;

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                win_data = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ready = '0;
        if (transfer) begin
            ready[win] = 1'b1;
        end
    end

    assign bus.req_ready = ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            cnt <= '0;
        end else if (transfer) begin
            ptr <= (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
            cnt <= cnt + CNTW'(1);
        end
    end

    // Data and id of stage 0 are only loaded on a transfer; a bubble just
    // clears the valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_valid <= '0;
            st_id    <= '0;
            st_data  <= '0;
        end else if (!bus.hold) begin
            st_valid[0] <= transfer;
            if (transfer) begin
                st_id[0]   <= win;
                st_data[0] <= win_data;
            end
            for (int k = 1; k < DEPTH; k++) begin
                st_valid[k] <= st_valid[k-1];
                st_id[k]    <= st_id[k-1];
                st_data[k]  <= st_data[k-1];
            end
        end
    end

    assign bus.out_valid  = st_valid[DEPTH-1];
    assign bus.out_id     = st_id[DEPTH-1];
    assign bus.out_data   = st_data[DEPTH-1];
    assign bus.busy       = |st_valid;
    assign bus.accept_cnt = cnt;
endmodule

// File: tb/tb_delay_scheduler.sv
// Directed bench for delay_scheduler: arbitration order, latency, hold, reset
// in flight and counter wrap (second instance with a 4-bit counter).
module tb_delay_scheduler;
    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int DEPTH = 2;
    localparam int CNTW  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    delay_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) bus ();
    delay_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .CNTW(4))    bus4 ();

    assign bus4.req_valid = bus.req_valid;
    assign bus4.req_data  = bus.req_data;
    assign bus4.hold      = bus.hold;

    delay_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .DEPTH(DEPTH), .CNTW(CNTW)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    delay_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .DEPTH(DEPTH), .CNTW(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.hold      = 1'b0;
    endtask

    task automatic set_word(input int i, input logic [31:0] d);
        bus.req_data[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic do_reset();
        tick();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        bus.req_valid = 4'hF;
        #12;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
        checks++; if (bus.out_id !== 2'd0) begin errors++; $display("FAIL reset_out_id: got %0d expected 0", bus.out_id); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.accept_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", bus.accept_cnt); end
        tick();
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            tick();
            idle();
            if (c == 5) begin
                bus.req_valid = 4'b0100;
                set_word(2, 32'hDEADBEEF);
            end
            #1;
            if (c == 5) begin
                checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", bus.req_ready); end
            end
            checks++; if (bus.out_valid !== (c == 7)) begin errors++; $display("FAIL single_out_valid c%0d: got %b expected %b", c, bus.out_valid, (c == 7)); end
            if (c == 6) begin
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
            end
            if (c == 7) begin
                checks++; if (bus.out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h expected deadbeef", bus.out_data); end
                checks++; if (bus.out_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d expected 2", bus.out_id); end
            end
            if (c == 8) begin
                checks++; if (bus.accept_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", bus.accept_cnt); end
                checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", bus.busy); end
            end
        end
    endtask

    task automatic test_contention();
        logic [3:0]  exp_r;
        logic [1:0]  exp_id;
        logic [31:0] exp_d;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i < 8) begin
                bus.req_valid = 4'hF;
                for (int j = 0; j < NREQ; j++) set_word(j, 32'h10 + j);
            end else begin
                idle();
            end
            #1;
            if (i < 8) begin
                exp_r = 4'b0001 << (i % 4);
                checks++; if (bus.req_ready !== exp_r) begin errors++; $display("FAIL cont_ready c%0d: got %b expected %b", i, bus.req_ready, exp_r); end
            end
            if (i >= 2) begin
                exp_id = 2'((i - 2) % 4);
                exp_d  = 32'h10 + 32'((i - 2) % 4);
                checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL cont_valid c%0d: got %b expected 1", i, bus.out_valid); end
                checks++; if (bus.out_id !== exp_id) begin errors++; $display("FAIL cont_id c%0d: got %0d expected %0d", i, bus.out_id, exp_id); end
                checks++; if (bus.out_data !== exp_d) begin errors++; $display("FAIL cont_data c%0d: got %h expected %h", i, bus.out_data, exp_d); end
            end
        end
        tick();
        #1;
        checks++; if (bus.accept_cnt !== 16'd8) begin errors++; $display("FAIL cont_cnt: got %0d expected 8", bus.accept_cnt); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL cont_tail: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_ptr_wrap();
        do_reset();
        tick();
        bus.req_valid = 4'b1000;
        set_word(3, 32'h3333);
        #1;
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_first: got %b expected 1000", bus.req_ready); end
        tick();
        bus.req_valid = 4'b1010;
        set_word(1, 32'h1111);
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_req1: got %b expected 0010", bus.req_ready); end
        tick();
        #1;
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_req3: got %b expected 1000", bus.req_ready); end
        tick();
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_req1_again: got %b expected 0010", bus.req_ready); end
        tick();
        idle();
    endtask

    task automatic test_hold();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            tick();
            idle();
            if (c == 0) begin bus.req_valid = 4'b0001; set_word(0, 32'hAAAA0001); end
            if (c == 1) begin bus.req_valid = 4'b0010; set_word(1, 32'hBBBB0002); end
            if (c >= 2 && c <= 4) begin bus.hold = 1'b1; bus.req_valid = 4'b0100; set_word(2, 32'hC0C0C0C0); end
            #1;
            if (c == 0) begin
                checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL hold_grant_a: got %b expected 0001", bus.req_ready); end
            end
            if (c == 1) begin
                checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL hold_grant_b: got %b expected 0010", bus.req_ready); end
            end
            if (c >= 2 && c <= 4) begin
                checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL hold_ready c%0d: got %b expected 0000", c, bus.req_ready); end
                checks++; if (bus.accept_cnt !== 16'd2) begin errors++; $display("FAIL hold_cnt c%0d: got %0d expected 2", c, bus.accept_cnt); end
            end
            if (c == 5) begin
                checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_a_valid: got %b expected 1", bus.out_valid); end
                checks++; if (bus.out_data !== 32'hAAAA0001) begin errors++; $display("FAIL hold_a_data: got %h expected aaaa0001", bus.out_data); end
                checks++; if (bus.out_id !== 2'd0) begin errors++; $display("FAIL hold_a_id: got %0d expected 0", bus.out_id); end
            end
            if (c == 6) begin
                checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_b_valid: got %b expected 1", bus.out_valid); end
                checks++; if (bus.out_data !== 32'hBBBB0002) begin errors++; $display("FAIL hold_b_data: got %h expected bbbb0002", bus.out_data); end
                checks++; if (bus.out_id !== 2'd1) begin errors++; $display("FAIL hold_b_id: got %0d expected 1", bus.out_id); end
            end
            if (c == 7) begin
                checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_tail: got %b expected 0", bus.out_valid); end
            end
        end
    endtask

    task automatic test_reset_flight();
        do_reset();
        tick();
        bus.req_valid = 4'b0001;
        set_word(0, 32'hA0A0A0A0);
        tick();
        bus.req_valid = 4'b0010;
        set_word(1, 32'hB0B0B0B0);
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstf_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstf_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.accept_cnt !== 16'd0) begin errors++; $display("FAIL rstf_cnt: got %0d expected 0", bus.accept_cnt); end
        tick();
        rst_n = 1'b1;
        bus.req_valid = 4'b1010;
        set_word(1, 32'hC1C1C1C1);
        set_word(3, 32'hD3D3D3D3);
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rstf_grant: got %b expected 0010", bus.req_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstf_ghost1: got %b expected 0", bus.out_valid); end
        tick();
        idle();
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstf_ghost2: got %b expected 0", bus.out_valid); end
        tick();
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstf_c_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.out_id !== 2'd1) begin errors++; $display("FAIL rstf_c_id: got %0d expected 1", bus.out_id); end
        checks++; if (bus.out_data !== 32'hC1C1C1C1) begin errors++; $display("FAIL rstf_c_data: got %h expected c1c1c1c1", bus.out_data); end
        tick();
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstf_tail: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            tick();
            bus.req_valid = 4'b0001;
            set_word(0, 32'(i));
            #1;
            if (i == 16) begin
                checks++; if (bus4.accept_cnt !== 4'd0) begin errors++; $display("FAIL wrap4_16: got %0d expected 0", bus4.accept_cnt); end
                checks++; if (bus.accept_cnt !== 16'd16) begin errors++; $display("FAIL wrap16_16: got %0d expected 16", bus.accept_cnt); end
            end
        end
        tick();
        idle();
        #1;
        checks++; if (bus4.accept_cnt !== 4'd1) begin errors++; $display("FAIL wrap4_17: got %0d expected 1", bus4.accept_cnt); end
        checks++; if (bus.accept_cnt !== 16'd17) begin errors++; $display("FAIL wrap16_17: got %0d expected 17", bus.accept_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_ptr_wrap();
        test_hold();
        test_reset_flight();
        test_cnt_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/delay_scheduler.md
# delay_scheduler

Shares one fixed-latency 32-bit delay pipeline between NREQ requesters of the solver datapath. Each cycle a round-robin arbiter grants at most one valid requester. The granted word is pushed into a DEPTH-stage register pipeline, tagged with the requester index. The word emerges DEPTH cycles later with its tag, so downstream logic can realign operands without a private delay line per lane.

## Interface
- WIDTH, 32, data width of each word.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, tag width; equals clog2(NREQ).
- DEPTH, 2, pipeline latency in cycles (1..8).
- CNTW, 16, width of the accepted-word counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  bit i set: requester i presents a word.
- req_data  in  NREQ*WIDTH  word of requester i in bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot grant; combinational from req_valid, hold and the pointer.
- hold  in  1  freezes arbitration and the pipeline.
- out_valid  out  1  registered; out_data/out_id are meaningful.
- out_data  out  WIDTH  registered delayed word.
- out_id  out  IDW  registered index of the originating requester.
- busy  out  1  OR of all stage valid bits.
- accept_cnt  out  CNTW  count of accepted words; wraps modulo 2^CNTW.

## Operation
Arbiter:
- Holds a round-robin pointer ptr, 0..NREQ-1.
- Searches ptr, ptr+1, …, ptr+NREQ-1 (mod NREQ). The first requester with req_valid=1 wins.
- req_ready[win]=1 only if hold=0. All other req_ready bits are 0.
- A transfer happens when req_valid[i] & req_ready[i] in the same cycle. At most one transfer per cycle.
- After a transfer, ptr <= (win+1) mod NREQ, including the wrap from NREQ-1 to 0. With no transfer, ptr is unchanged.

Pipeline:
- Stages s[0..DEPTH-1], each holding {valid, id, data}.
- On each clock edge with hold=0:
  - s[0] <= {transfer, win, req_data[win]}.
  - s[k] <= s[k-1].
  - On a cycle with no transfer, s[0].valid <= 0. Data and id may keep old values, but must not be relied on.
- On an edge with hold=1, all stages, ptr and accept_cnt keep their values.
- out_valid/out_id/out_data are driven from s[DEPTH-1].
- out_valid is not back-pressured. Consumers must take the word in the cycle it is shown, unless they assert hold.

Counter:
- accept_cnt increments by 1 on every transfer edge.
- It wraps from 2^CNTW-1 to 0.

Reset (asynchronous, rst_n=0):
- All stage valid bits, ids and data go to 0, so out_valid=0, out_data=0, out_id=0.
- ptr=0, accept_cnt=0, busy=0.
- req_ready=0 while rst_n=0.
- Words in flight are discarded and never reappear. The first grant after release starts the search at requester 0.

## Timing
- Latency: a word transferred in cycle c is on out_data with out_valid=1 throughout cycle c+DEPTH, provided no hold cycle intervenes.
- Each hold=1 cycle adds exactly one cycle of latency to every word in flight.
- Throughput: one word per cycle. Back-to-back transfers appear on consecutive output cycles, in acceptance order.
- hold affects req_ready in the same cycle, with no registered lag.
- busy is registered and is 1 in any cycle where at least one stage holds a valid word.
- Simultaneous requests: only the winner sees req_ready. Losers must hold req_valid and req_data stable until they are granted.
- A requester that deasserts req_valid before its grant loses nothing. There is no pending state.

## Test plan
- Single requester: NREQ=4, DEPTH=2, only req 2 valid with data 0xDEADBEEF in cycle 5 -> req_ready=4'b0100 in cycle 5; out_valid=1, out_data=0xDEADBEEF, out_id=2 in cycle 7 only; accept_cnt=1.
- Full contention: all four valid continuously for 8 cycles with data 0x10+i -> grant order 0,1,2,3,0,1,2,3; out_id sequence identical, starting at cycle 2; no bubbles; accept_cnt=8.
- Pointer wrap: req 3 granted, then only req 1 and req 3 valid -> req 1 wins next (search starts at 0), then req 3.
- Hold mid-stream: two back-to-back words A then B, hold=1 for 3 cycles starting one cycle after B is accepted -> no req_ready during hold; A and B each arrive 3 cycles late, still consecutive; accept_cnt unchanged during hold.
- Reset in flight: rst_n low for 1 cycle while two words are in the pipe -> out_valid, busy and accept_cnt read 0 immediately; neither word ever appears; the next grant goes to the lowest valid index from 0.
- Counter wrap: CNTW=4, 17 transfers -> accept_cnt=1.
